// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, AXI response code, FSM state types and the byte-strobe mask helper
package gpio_pkg;
  localparam logic [3:0] GPIO_DATA_OUT_OFS   = 4'h0;
  localparam logic [3:0] GPIO_DIR_OFS        = 4'h4;
  localparam logic [3:0] GPIO_DATA_IN_OFS    = 4'h8;
  localparam logic [3:0] GPIO_IRQ_STATUS_OFS = 4'hC;
  localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: per-bit input synchroniser; with GPIO_IRQ_EN it adds a delay flop for rising-edge detect
module gpio_in_sync #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] sync,
  output logic [GPIO_WIDTH-1:0] rise
);
  logic [GPIO_WIDTH-1:0] stg_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] stg_d [SYNC_STAGES];
  always_comb begin
    stg_d[0] = gpio_i;
    for (int i = 1; i < SYNC_STAGES; i++) stg_d[i] = stg_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < SYNC_STAGES; i++) stg_q[i] <= '0;
    else stg_q <= stg_d;
  end
  assign sync = stg_q[SYNC_STAGES-1];
`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] prev_q, prev_d;
  assign prev_d = sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else prev_q <= prev_d;
  end
  assign rise = sync & ~prev_q;
`else
  assign rise = '0;
`endif
endmodule

// File: rtl/gpio_axil_slave.sv
// gpio_axil_slave: AXI4-Lite GPIO register block (DATA_OUT, DIR, DATA_IN, IRQ_STATUS)
// Define GPIO_IRQ_EN to build the rising-edge interrupt latch; otherwise IRQ_STATUS reads 0 and irq is 0.
module gpio_axil_slave
  import gpio_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int GPIO_WIDTH         = 32,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [GPIO_WIDTH-1:0]           gpio_i,
  output logic [GPIO_WIDTH-1:0]           gpio_o,
  output logic [GPIO_WIDTH-1:0]           gpio_t,
  output logic                            irq
);
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_got_q, aw_got_d, w_got_q, w_got_d, irq_q, irq_d;
  logic [1:0] awsel_q, awsel_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, wmask, rd_val;
  logic [GPIO_WIDTH-1:0] data_out_q, data_out_d, dir_q, dir_d, irq_status_q, irq_status_d;
  logic [GPIO_WIDTH-1:0] sync, rise;
  logic aw_hs, w_hs, ar_hs, wr_en, unused_ok;
  function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old,
                                                  input logic [31:0] val, input logic [31:0] m);
    return GPIO_WIDTH'((32'(old) & ~m) | (val & m));
  endfunction
  gpio_in_sync #(.GPIO_WIDTH(GPIO_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_in_sync (
    .clk(s00_axi_aclk), .rst_n(s00_axi_aresetn), .gpio_i(gpio_i), .sync(sync), .rise(rise)
  );
  always_comb begin
    s00_axi_awready = (w_state_q == W_IDLE) | ((w_state_q == W_WAIT) & ~aw_got_q);
    s00_axi_wready  = (w_state_q == W_IDLE) | ((w_state_q == W_WAIT) & ~w_got_q);
    s00_axi_bvalid  = w_state_q == W_RESP;
    s00_axi_arready = r_state_q == R_IDLE;
    s00_axi_rvalid  = r_state_q == R_DATA;
  end
  assign s00_axi_bresp = AXI_RESP_OKAY;
  assign s00_axi_rresp = AXI_RESP_OKAY;
  assign s00_axi_rdata = rdata_q;
  assign gpio_o = data_out_q;
  assign gpio_t = ~dir_q;
  assign irq = irq_q;
  assign aw_hs = s00_axi_awvalid & s00_axi_awready;
  assign w_hs  = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs = s00_axi_arvalid & s00_axi_arready;
  // The update fires on whichever edge completes the AW/W pair, using live or held halves.
  assign wr_en = (aw_got_q | aw_hs) & (w_got_q | w_hs);
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0], rise};
  always_comb begin
    w_state_d = wr_en ? W_RESP : (aw_hs | w_hs) ? W_WAIT
              : ((w_state_q == W_RESP) & s00_axi_bready) ? W_IDLE : w_state_q;
    r_state_d = ar_hs ? R_DATA : ((r_state_q == R_DATA) & s00_axi_rready) ? R_IDLE : r_state_q;
  end
  always_comb begin
    aw_got_d   = (aw_got_q | aw_hs) & ~wr_en;
    w_got_d    = (w_got_q | w_hs) & ~wr_en;
    awsel_d    = aw_hs ? s00_axi_awaddr[3:2] : awsel_q;
    wdata_d    = w_hs ? s00_axi_wdata : wdata_q;
    wstrb_d    = w_hs ? s00_axi_wstrb : wstrb_q;
    wmask      = strb_mask(wstrb_d);
    data_out_d = (wr_en & ({awsel_d, 2'b00} == GPIO_DATA_OUT_OFS)) ? merge(data_out_q, wdata_d, wmask) : data_out_q;
    dir_d      = (wr_en & ({awsel_d, 2'b00} == GPIO_DIR_OFS)) ? merge(dir_q, wdata_d, wmask) : dir_q;
`ifdef GPIO_IRQ_EN
    irq_status_d = (irq_status_q & ~((wr_en & ({awsel_d, 2'b00} == GPIO_IRQ_STATUS_OFS))
                   ? GPIO_WIDTH'(wdata_d & wmask) : '0)) | rise;
    irq_d        = |irq_status_d;
`else
    irq_status_d = '0;
    irq_d        = 1'b0;
`endif
    rd_val  = ({s00_axi_araddr[3:2], 2'b00} == GPIO_DATA_OUT_OFS) ? 32'(data_out_q)
            : ({s00_axi_araddr[3:2], 2'b00} == GPIO_DIR_OFS) ? 32'(dir_q)
            : ({s00_axi_araddr[3:2], 2'b00} == GPIO_DATA_IN_OFS) ? 32'(sync) : 32'(irq_status_q);
    rdata_d = ar_hs ? rd_val : rdata_q;
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      aw_got_q     <= 1'b0;
      w_got_q      <= 1'b0;
      awsel_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      aw_got_q     <= aw_got_d;
      w_got_q      <= w_got_d;
      awsel_q      <= awsel_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
    end
  end
endmodule

// File: tb/tb_gpio_axil_slave.sv
// tb_gpio_axil_slave: randomized AXI4-Lite traffic against a register-level model of the GPIO block
module tb_gpio_axil_slave;
  localparam int SYNC = 2;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] awaddr = '0, araddr = '0, wstrb = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0, rdata, gpio_i = '0, gpio_o, gpio_t;
  logic [1:0] bresp, rresp;
  logic awready, wready, bvalid, arready, rvalid, irq;
  int n_checks = 0, n_errors = 0;
  logic [31:0] m_dout, m_dir, m_stat, m_pins;

  gpio_axil_slave #(.GPIO_WIDTH(32), .SYNC_STAGES(SYNC)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] smask(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m |= 32'hFF << (8 * b);
    return m;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0: return m_dout;
      2'd1: return m_dir;
      2'd2: return m_pins;
      default: return m_stat;
    endcase
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m = smask(s);
    case (a[3:2])
      2'd0: m_dout = (m_dout & ~m) | (d & m);
      2'd1: m_dir = (m_dir & ~m) | (d & m);
      2'd3: if (IRQ_EN) m_stat &= ~(d & m);
      default: ;
    endcase
  endtask

  task automatic m_pins_to(input logic [31:0] v);
    if (IRQ_EN) m_stat |= v & ~m_pins;
    m_pins = v;
  endtask

  task automatic m_reset();
    m_dout = '0;
    m_dir = '0;
    m_stat = '0;
    m_pins = '0;
  endtask

  task automatic set_pins(input logic [31:0] v);
    gpio_i = v;
    cyc(SYNC + 2);
    m_pins_to(v);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly, output logic [1:0] resp);
    int aws = lead < 0 ? -lead : 0;
    int ws = lead > 0 ? lead : 0;
    int t = 0;
    bit ad = 0, wd = 0, ah, wh, bad = 0, lost = 0;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awprot = 3'($urandom);
    while (!(ad && wd) && t < 50) begin
      if (t == aws && !ad) awvalid = 1;
      if (t == ws && !wd) wvalid = 1;
      if ((ad && awready) || (wd && wready) || bvalid) bad = 1;
      ah = awvalid & awready;
      wh = wvalid & wready;
      cyc(1);
      t++;
      if (ah) begin awvalid = 0; ad = 1; end
      if (wh) begin wvalid = 0; wd = 1; end
    end
    check("wr_accept", 32'({ad, wd}), 32'd3);
    check("wr_ready_held", 32'(bad), 32'd0);
    check("bvalid_next", 32'(bvalid), 32'd1);
    for (int i = 0; i < bdly; i++) begin
      if (!bvalid) lost = 1;
      cyc(1);
    end
    check("bvalid_hold", 32'(lost), 32'd0);
    bready = 1;
    t = 0;
    while (!bvalid && t < 20) begin cyc(1); t++; end
    resp = bresp;
    cyc(1);
    bready = 0;
    check("b_single", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int rdly, output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    bit unstable = 0;
    araddr = a;
    arprot = 3'($urandom);
    arvalid = 1;
    while (!arready && t < 20) begin cyc(1); t++; end
    cyc(1);
    arvalid = 0;
    check("rvalid_next", 32'(rvalid), 32'd1);
    data = rdata;
    for (int i = 0; i < rdly; i++) begin
      if (!rvalid || rdata !== data) unstable = 1;
      cyc(1);
    end
    check("rdata_stable", 32'(unstable), 32'd0);
    rready = 1;
    resp = rresp;
    cyc(1);
    rready = 0;
    check("r_single", 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, v, old;
    logic [1:0] br, rr;
    logic [3:0] a, s;
    m_reset();
    cyc(3);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_gpio_o", gpio_o, 32'h0);
    check("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1;
    cyc(2);
    // basic RW
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, br); m_write(4'h0, 32'h1, 4'hF);
    check("bresp_dout", 32'(br), 32'd0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, br); m_write(4'h4, 32'h2, 4'hF);
    check("bresp_dir", 32'(br), 32'd0);
    axi_read(4'h0, 0, rd, rr);
    check("rd_dout", rd, 32'h1);
    check("rresp", 32'(rr), 32'd0);
    axi_read(4'h4, 1, rd, rr);
    check("rd_dir", rd, 32'h2);
    check("gpio_o_basic", gpio_o, 32'h1);
    check("gpio_t_basic", gpio_t, 32'hFFFF_FFFD);
    // byte strobes
    axi_write(4'h0, 32'hAABBCCDD, 4'hF, 0, 0, br); m_write(4'h0, 32'hAABBCCDD, 4'hF);
    axi_write(4'h1, 32'h11223344, 4'h5, 0, 0, br); m_write(4'h0, 32'h11223344, 4'h5);
    axi_read(4'h2, 0, rd, rr);
    check("rd_strobe", rd, 32'hAA22CC44);
    // AW leads W by 3 cycles, bready withheld 4 cycles
    v = $urandom;
    axi_write(4'h4, v, 4'hF, 3, 4, br); m_write(4'h4, v, 4'hF);
    axi_read(4'h4, 0, rd, rr);
    check("rd_aw_first", rd, m_dir);
    v = $urandom;
    axi_write(4'h0, v, 4'hF, -2, 2, br); m_write(4'h0, v, 4'hF);
    axi_read(4'h0, 0, rd, rr);
    check("rd_w_first", rd, m_dout);
    // DATA_IN latency: sampled SYNC edges after the change is still old, SYNC+1 edges is new
    gpio_i = 32'hF0;
    cyc(SYNC - 1);
    axi_read(4'h8, 0, rd, rr);
    check("din_early", rd, 32'h0);
    m_pins_to(32'hF0);
    gpio_i = 32'h1F0;
    cyc(SYNC);
    axi_read(4'h8, 0, rd, rr);
    check("din_ontime", rd, 32'h1F0);
    m_pins_to(32'h1F0);
    axi_write(4'h8, 32'hFFFF, 4'hF, 0, 0, br); m_write(4'h8, 32'hFFFF, 4'hF);
    axi_read(4'h8, 0, rd, rr);
    check("din_ro", rd, 32'h1F0);
    // interrupt latch
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, br); m_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    set_pins(32'h1F8);
    axi_read(4'hC, 0, rd, rr);
    check("irq_set", rd, m_stat);
    check("irq_pin_set", 32'(irq), 32'(m_stat != 0));
    axi_write(4'hC, 32'h8, 4'hF, 0, 0, br); m_write(4'hC, 32'h8, 4'hF);
    axi_read(4'hC, 0, rd, rr);
    check("irq_clr", rd, m_stat);
    check("irq_pin_clr", 32'(irq), 32'(m_stat != 0));
    set_pins(32'h1F0);
    gpio_i = 32'h1F8;
    cyc(SYNC);
    axi_write(4'hC, 32'h8, 4'hF, 0, 0, br);
    m_write(4'hC, 32'h8, 4'hF);
    m_pins_to(32'h1F8);
    axi_read(4'hC, 0, rd, rr);
    check("irq_set_wins", rd, m_stat);
    check("irq_pin_wins", 32'(irq), 32'(m_stat != 0));
    // simultaneous read and write of the same register returns the old value
    old = m_dout;
    v = $urandom;
    fork
      axi_write(4'h0, v, 4'hF, 0, 0, br);
      axi_read(4'h0, 0, rd, rr);
    join
    m_write(4'h0, v, 4'hF);
    check("rw_same_cycle", rd, old);
    check("gpio_o_rw", gpio_o, m_dout);
    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      a = 4'($urandom);
      case ($urandom_range(0, 3))
        0, 1: begin
          v = $urandom;
          s = 4'($urandom);
          axi_write(a, v, s, $urandom_range(0, 6) - 3, $urandom_range(0, 3), br);
          m_write(a, v, s);
          check("rnd_bresp", 32'(br), 32'd0);
          check("rnd_gpio_o", gpio_o, m_dout);
          check("rnd_gpio_t", gpio_t, ~m_dir);
          check("rnd_irq", 32'(irq), 32'(m_stat != 0));
        end
        2: begin
          axi_read(a, $urandom_range(0, 3), rd, rr);
          check("rnd_rdata", rd, m_read(a));
          check("rnd_rresp", 32'(rr), 32'd0);
        end
        default: begin
          set_pins($urandom);
          check("rnd_pin_irq", 32'(irq), 32'(m_stat != 0));
        end
      endcase
    end
    // reset while both responses are pending
    awaddr = 4'h0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; araddr = 4'h4;
    awvalid = 1; wvalid = 1; arvalid = 1;
    cyc(1);
    awvalid = 0; wvalid = 0; arvalid = 0;
    cyc(1);
    check("pre_rst_bvalid", 32'(bvalid), 32'd1);
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    rst_n = 0;
    #1;
    check("rst_mid_bvalid", 32'(bvalid), 32'd0);
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_gpio_t", gpio_t, 32'hFFFF_FFFF);
    check("rst_mid_gpio_o", gpio_o, 32'h0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    cyc(2);
    rst_n = 1;
    m_reset();
    cyc(SYNC + 2);
    m_pins_to(gpio_i);
    axi_read(4'h0, 0, rd, rr);
    check("post_rst_dout", rd, 32'h0);
    // a lone AW captured before reset must not pair with a later W
    awaddr = 4'h4;
    awvalid = 1;
    cyc(1);
    awvalid = 0;
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    m_reset();
    cyc(SYNC + 2);
    m_pins_to(gpio_i);
    axi_write(4'h0, 32'h1234, 4'hF, -2, 0, br); m_write(4'h0, 32'h1234, 4'hF);
    axi_read(4'h0, 0, rd, rr);
    check("post_rst_write", rd, 32'h1234);
    axi_read(4'h4, 0, rd, rr);
    check("post_rst_dir", rd, m_dir);
    axi_read(4'hC, 0, rd, rr);
    check("post_rst_stat", rd, m_stat);
    check("post_rst_gpio_o", gpio_o, m_dout);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
